// File: rtl/fault_campaign_checker.sv
// Fault-campaign sequencer: walks every fault site through all 16 input
// vectors. For each vector it compares the fault-injected DUT output against
// the golden model y = (a|b) ^ (e|~f) and records per-fault statistics.
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE,
// is ignored while busy, and loses to rst when both are high. There is no
// back-pressure. done is a single-cycle pulse, and results stay readable
// until the next accepted start.
module fault_campaign_checker #(
  parameter int SETTLE     = 1,
  parameter int NUM_FAULTS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  input  logic [2:0] rd_idx,
  output logic       vec_a,
  output logic       vec_b,
  output logic       vec_e,
  output logic       vec_f,
  output logic       fault_en,
  output logic [2:0] fault_sel,
  output logic       busy,
  output logic       done,
  output logic [5:0] detected,
  output logic [7:0] total_mism,
  output logic [3:0] rd_first,
  output logic [4:0] rd_cnt,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Last value of the WAIT counter; WAIT is only entered when SETTLE > 1.
  localparam logic [1:0] WAIT_LAST  = 2'(SETTLE - 2);
  localparam logic [2:0] LAST_FAULT = 3'(NUM_FAULTS - 1);

  state_t      state_q, state_d;
  logic [3:0]  v_q, v_d;
  logic [2:0]  fault_q, fault_d;
  logic [1:0]  wait_q, wait_d;
  logic        fault_en_q, fault_en_d;
  logic [5:0]  det_q, det_d;
  logic [7:0]  tot_q, tot_d;
  logic [4:0]  cnt_q   [6];
  logic [4:0]  cnt_d   [6];
  logic [3:0]  first_q [6];
  logic [3:0]  first_d [6];
  logic        golden;

  // Next-state, campaign sequencing and result accumulation
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    fault_d = fault_q;
    wait_d  = wait_q;
    det_d   = det_q;
    tot_d   = tot_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    golden  = (v_q[3] | v_q[2]) ^ (v_q[1] | ~v_q[0]);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          v_d     = '0;
          fault_d = '0;
          wait_d  = '0;
          det_d   = '0;
          tot_d   = '0;
          for (int k = 0; k < 6; k++) begin
            cnt_d[k]   = '0;
            first_d[k] = 4'hF;
          end
        end
      end
      S_APPLY: begin
        wait_d  = '0;
        state_d = (SETTLE > 1) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_SAMPLE;
        else                     wait_d  = wait_q + 2'd1;
      end
      S_SAMPLE: begin
        if (dut_y != golden) begin
          if (cnt_q[fault_q] != 5'd16) cnt_d[fault_q] = cnt_q[fault_q] + 5'd1;
          if (tot_q != 8'hFF)          tot_d = tot_q + 8'd1;
          det_d[fault_q] = 1'b1;
          if (first_q[fault_q] == 4'hF) first_d[fault_q] = v_q;
        end
        if (v_q != 4'hF) begin
          v_d     = v_q + 4'd1;
          state_d = S_APPLY;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        v_d = '0;
        if (fault_q == LAST_FAULT) begin
          state_d = S_DONE;
        end else begin
          fault_d = fault_q + 3'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    fault_en_d = (state_d == S_APPLY) || (state_d == S_WAIT) ||
                 (state_d == S_SAMPLE) || (state_d == S_NEXT);
  end

  // State and result registers, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      v_q        <= '0;
      fault_q    <= '0;
      wait_q     <= '0;
      fault_en_q <= 1'b0;
      det_q      <= '0;
      tot_q      <= '0;
      for (int k = 0; k < 6; k++) begin
        cnt_q[k]   <= '0;
        first_q[k] <= 4'hF;
      end
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      fault_q    <= fault_d;
      wait_q     <= wait_d;
      fault_en_q <= fault_en_d;
      det_q      <= det_d;
      tot_q      <= tot_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
    end
  end

  // Combinational read-back of stored per-fault results
  always_comb begin
    rd_first = 4'hF;
    rd_cnt   = '0;
    if (int'(rd_idx) < NUM_FAULTS) begin
      rd_first = first_q[rd_idx];
      rd_cnt   = cnt_q[rd_idx];
    end
  end

  assign vec_a      = v_q[3];
  assign vec_b      = v_q[2];
  assign vec_e      = v_q[1];
  assign vec_f      = v_q[0];
  assign fault_en   = fault_en_q;
  assign fault_sel  = fault_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign detected   = det_q;
  assign total_mism = tot_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fault_campaign_checker.sv
// Bench for fault_campaign_checker. Two instances share clk/rst/start/rd_idx:
// instance 0 uses SETTLE=1 with a combinational fault-injected DUT, and
// instance 1 uses SETTLE=3 with the same DUT delayed by three cycles.
module tb_fault_campaign_checker;

  localparam int SETTLE_OF [2] = '{1, 3};

  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] rd_idx;

  always #5 clk = ~clk;

  logic       dut_y_w    [2];
  logic       vec_a_w    [2];
  logic       vec_b_w    [2];
  logic       vec_e_w    [2];
  logic       vec_f_w    [2];
  logic       fault_en_w [2];
  logic [2:0] fault_sel_w[2];
  logic       busy_w     [2];
  logic       done_w     [2];
  logic [5:0] det_w      [2];
  logic [7:0] tot_w      [2];
  logic [3:0] first_w    [2];
  logic [4:0] cnt_w      [2];
  logic [2:0] dbg_w      [2];

  fault_campaign_checker #(.SETTLE(1), .NUM_FAULTS(6)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .dut_y(dut_y_w[0]), .rd_idx(rd_idx),
    .vec_a(vec_a_w[0]), .vec_b(vec_b_w[0]), .vec_e(vec_e_w[0]), .vec_f(vec_f_w[0]),
    .fault_en(fault_en_w[0]), .fault_sel(fault_sel_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .detected(det_w[0]), .total_mism(tot_w[0]),
    .rd_first(first_w[0]), .rd_cnt(cnt_w[0]), .dbg_state(dbg_w[0])
  );

  fault_campaign_checker #(.SETTLE(3), .NUM_FAULTS(6)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .dut_y(dut_y_w[1]), .rd_idx(rd_idx),
    .vec_a(vec_a_w[1]), .vec_b(vec_b_w[1]), .vec_e(vec_e_w[1]), .vec_f(vec_f_w[1]),
    .fault_en(fault_en_w[1]), .fault_sel(fault_sel_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .detected(det_w[1]), .total_mism(tot_w[1]),
    .rd_first(first_w[1]), .rd_cnt(cnt_w[1]), .dbg_state(dbg_w[1])
  );

  // Environment: 0 = real fault injection, 1 = DUT ignores faults,
  // 2 = golden output xor a random per-fault/per-vector flip mask.
  int          mode = 0;
  logic [15:0] flip [6];

  function automatic logic faulty_y(input logic [3:0] v, input logic en,
                                    input logic [2:0] sel);
    logic s1, s2, y;
    s1 = v[3] | v[2];
    s2 = v[1] | ~v[0];
    if (mode == 1 || !en || sel > 3'd5) return s1 ^ s2;
    if (mode == 2) return (s1 ^ s2) ^ flip[sel][v];
    case (sel)
      3'd0: s1 = 1'b0;
      3'd1: s1 = 1'b1;
      3'd2: s2 = 1'b0;
      3'd3: s2 = 1'b1;
      default: ;
    endcase
    y = s1 ^ s2;
    if (sel == 3'd4) y = 1'b0;
    if (sel == 3'd5) y = 1'b1;
    return y;
  endfunction

  always_comb dut_y_w[0] = faulty_y({vec_a_w[0], vec_b_w[0], vec_e_w[0], vec_f_w[0]},
                                    fault_en_w[0], fault_sel_w[0]);

  logic [2:0] dly = '0;
  always @(posedge clk) begin
    dly[0] <= faulty_y({vec_a_w[1], vec_b_w[1], vec_e_w[1], vec_f_w[1]},
                       fault_en_w[1], fault_sel_w[1]);
    dly[1] <= dly[0];
    dly[2] <= dly[1];
  end
  always_comb dut_y_w[1] = dly[2];

  // Reference results derived from the fault rules over all 16 vectors.
  int         exp_cnt   [6];
  int         exp_first [6];
  int         exp_total;
  logic [5:0] exp_det;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic compute_expected();
    exp_total = 0;
    exp_det   = '0;
    for (int k = 0; k < 6; k++) begin
      exp_cnt[k]   = 0;
      exp_first[k] = 15;
      for (int v = 0; v < 16; v++) begin
        logic [3:0] vv;
        logic g;
        vv = 4'(v);
        g  = (vv[3] | vv[2]) ^ (vv[1] | ~vv[0]);
        if (faulty_y(vv, 1'b1, 3'(k)) != g) begin
          if (exp_cnt[k] == 0) exp_first[k] = v;
          exp_cnt[k]++;
          exp_total++;
          exp_det[k] = 1'b1;
        end
      end
    end
    if (exp_total > 255) exp_total = 255;
  endtask

  task automatic set_reset_expected();
    exp_total = 0;
    exp_det   = '0;
    for (int k = 0; k < 6; k++) begin
      exp_cnt[k]   = 0;
      exp_first[k] = 15;
    end
  endtask

  task automatic check_results(input string tag);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (det_w[j] !== exp_det) begin
        n_fail++;
        $display("FAIL %s detected inst%0d got %h want %h", tag, j, det_w[j], exp_det);
      end
      n_checks++;
      if (tot_w[j] !== 8'(exp_total)) begin
        n_fail++;
        $display("FAIL %s total_mism inst%0d got %0d want %0d", tag, j, tot_w[j], exp_total);
      end
    end
    for (int i = 0; i < 8; i++) begin
      logic [3:0] wf;
      logic [4:0] wc;
      rd_idx = 3'(i);
      wf = (i < 6) ? 4'(exp_first[i]) : 4'hF;
      wc = (i < 6) ? 5'(exp_cnt[i]) : 5'd0;
      #2;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (first_w[j] !== wf || cnt_w[j] !== wc) begin
          n_fail++;
          $display("FAIL %s rd[%0d] inst%0d got first=%h cnt=%0d want first=%h cnt=%0d",
                   tag, i, j, first_w[j], cnt_w[j], wf, wc);
        end
      end
      @(negedge clk);
    end
  endtask

  // Runs one campaign on both instances and checks timing and pulse shape.
  task automatic run_campaign(input string tag, input bit repulse);
    int  rise [2];
    int  donec[2];
    int  ndone[2];
    bit  fin  [2];
    for (int j = 0; j < 2; j++) begin
      rise[j] = -1; donec[j] = -1; ndone[j] = 0; fin[j] = 1'b0;
    end
    if (repulse) rd_idx = 3'd7;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (busy_w[j] && rise[j] < 0) rise[j] = cyc;
        if (done_w[j]) begin
          ndone[j]++;
          donec[j] = cyc;
          n_checks++;
          if (busy_w[j] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_in_done inst%0d got %b want 1", tag, j, busy_w[j]);
          end
        end
        if (!fin[j] && donec[j] >= 0 && cyc == donec[j] + 1) begin
          fin[j] = 1'b1;
          n_checks++;
          if (busy_w[j] !== 1'b0 || done_w[j] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done inst%0d got busy=%b done=%b want 0 0",
                     tag, j, busy_w[j], done_w[j]);
          end
        end
      end
      if (repulse && cyc == 50) begin
        for (int j = 0; j < 2; j++) begin
          n_checks++;
          if (first_w[j] !== 4'hF || cnt_w[j] !== 5'd0) begin
            n_fail++;
            $display("FAIL %s rd7_busy inst%0d got first=%h cnt=%0d want F 0",
                     tag, j, first_w[j], cnt_w[j]);
          end
        end
      end
      start = (repulse && cyc < 150 && $urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      if (fin[0] && fin[1]) break;
    end
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      int want_len;
      want_len = 6 * (16 * (SETTLE_OF[j] + 1) + 1);
      n_checks++;
      if (!fin[j] || rise[j] != 1 || ndone[j] != 1 || donec[j] - rise[j] != want_len) begin
        n_fail++;
        $display("FAIL %s timing inst%0d got rise=%0d done_at=%0d pulses=%0d want rise=1 len=%0d pulses=1",
                 tag, j, rise[j], donec[j], ndone[j], want_len);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rd_idx = '0;
    repeat (3) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if ({vec_a_w[j], vec_b_w[j], vec_e_w[j], vec_f_w[j]} !== 4'b0 ||
          fault_en_w[j] !== 1'b0 || fault_sel_w[j] !== 3'd0 || busy_w[j] !== 1'b0 ||
          done_w[j] !== 1'b0 || det_w[j] !== 6'd0 || tot_w[j] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d got vec=%b en=%b sel=%0d busy=%b done=%b det=%h tot=%0d want all 0",
                 j, {vec_a_w[j], vec_b_w[j], vec_e_w[j], vec_f_w[j]}, fault_en_w[j],
                 fault_sel_w[j], busy_w[j], done_w[j], det_w[j], tot_w[j]);
      end
    end
    n_checks++;
    if (dbg_w[0] !== dbg_w[1]) begin
      n_fail++;
      $display("FAIL reset_state_match got %0d vs %0d want equal", dbg_w[0], dbg_w[1]);
    end
    set_reset_expected();
    check_results("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_and_start();
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (busy_w[j] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_beats_start inst%0d busy got %b want 0", j, busy_w[j]);
      end
    end
  endtask

  task automatic test_fault_campaign();
    mode = 0;
    compute_expected();
    run_campaign("fault", 1'b0);
    check_results("fault");
  endtask

  task automatic test_golden_table();
    int tc [6] = '{12, 4, 12, 4, 6, 10};
    int tf [6] = '{4, 0, 0, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      rd_idx = 3'(i);
      #2;
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (cnt_w[j] !== 5'(tc[i]) || first_w[j] !== 4'(tf[i])) begin
          n_fail++;
          $display("FAIL table[%0d] inst%0d got cnt=%0d first=%0d want cnt=%0d first=%0d",
                   i, j, cnt_w[j], first_w[j], tc[i], tf[i]);
        end
      end
      @(negedge clk);
    end
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (tot_w[j] !== 8'd48 || det_w[j] !== 6'h3F) begin
        n_fail++;
        $display("FAIL table_totals inst%0d got tot=%0d det=%h want 48 3f", j, tot_w[j], det_w[j]);
      end
    end
  endtask

  task automatic test_ignore_faults();
    mode = 1;
    compute_expected();
    run_campaign("ignore", 1'b0);
    check_results("ignore");
  endtask

  task automatic test_random_flips();
    for (int it = 0; it < 3; it++) begin
      mode = 2;
      for (int k = 0; k < 6; k++) flip[k] = 16'($urandom());
      if (it == 0) begin
        flip[0] = 16'hFFFF;
        flip[1] = 16'h0000;
        flip[2] = 16'h8000;
      end
      compute_expected();
      run_campaign("flips", 1'b0);
      check_results("flips");
    end
  endtask

  task automatic test_persist();
    repeat ($urandom_range(5, 40)) @(negedge clk);
    check_results("persist");
  endtask

  task automatic test_rst_abort();
    bit seen;
    int ndone;
    mode = 0;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      if (busy_w[0] && fault_sel_w[0] == 3'd2) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_reach_fault2 got not reached want reached");
    end
    repeat ($urandom_range(0, 20)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int j = 0; j < 2; j++) begin
      n_checks++;
      if (busy_w[j] !== 1'b0 || fault_en_w[j] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_idle inst%0d got busy=%b en=%b want 0 0", j, busy_w[j], fault_en_w[j]);
      end
    end
    for (int c = 0; c < 450; c++) begin
      if (done_w[0] || done_w[1]) ndone++;
      @(negedge clk);
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL abort_no_done got %0d pulses want 0", ndone);
    end
    set_reset_expected();
    check_results("abort");
    compute_expected();
    run_campaign("after_abort", 1'b0);
    check_results("after_abort");
  endtask

  task automatic test_start_while_busy();
    mode = 0;
    compute_expected();
    run_campaign("restart", 1'b1);
    check_results("restart");
  endtask

  initial begin
    test_reset();
    test_rst_and_start();
    test_fault_campaign();
    test_golden_table();
    test_persist();
    test_ignore_faults();
    test_random_flips();
    test_rst_abort();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fault_campaign_checker.md
FAULT_CAMPAIGN_CHECKER -- requirements
Module: fault_campaign_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning cycles between driving a vector and sampling dut_y (legal range 1..4).
REQ-002 The block SHALL have parameter NUM_FAULTS, default 6, meaning fault sites exercised per campaign (legal range 1..6).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a campaign.
REQ-006 dut_y  input  1  output of the fault-injected DUT under the currently driven vector and fault.
REQ-007 vec_a, vec_b, vec_e, vec_f  output  1 each  stimulus to the DUT, registered.
REQ-008 fault_en  output  1  high while a fault is to be forced in the DUT.
REQ-009 fault_sel  output  3  fault site code: 0 sig1 stuck-0, 1 sig1 stuck-1, 2 sig2 stuck-0, 3 sig2 stuck-1, 4 y stuck-0, 5 y stuck-1.
REQ-010 busy  output  1  campaign in progress.
REQ-011 done  output  1  one-cycle pulse at campaign end.
REQ-012 detected  output  6  bit k set when fault k produced at least one mismatch.
REQ-013 total_mism  output  8  total mismatches across the campaign.
REQ-014 rd_idx  input  3  fault index to read back.
REQ-015 rd_first  output  4  first detecting vector index for fault rd_idx; 4'hF when undetected.
REQ-016 rd_cnt  output  5  mismatch count for fault rd_idx (0..16).

Function
REQ-017 Golden model SHALL be sig1=a|b, sig2=e|~f, y=sig1^sig2, evaluated on the driven vector.
REQ-018 Vector index v SHALL map to {vec_a,vec_b,vec_e,vec_f}={v[3],v[2],v[1],v[0]}, with v running 0..15 in ascending order for each fault.
REQ-019 FSM states SHALL be IDLE, APPLY, WAIT, SAMPLE, NEXT, DONE.
REQ-020 IDLE->APPLY on start; start SHALL be ignored while busy=1.
REQ-021 On leaving IDLE the block SHALL clear detected, total_mism, all per-fault counts, and set every rd_first to 4'hF.
REQ-022 APPLY SHALL drive vector v with fault_en=1 and fault_sel=current fault, then hold them for SETTLE-1 WAIT cycles; SAMPLE SHALL follow, so dut_y is compared exactly SETTLE cycles after the vector is driven.
REQ-023 In SAMPLE, if dut_y differs from golden y, the block SHALL increment the fault's count and total_mism, set its detected bit, and, if rd_first is 4'hF, record v.
REQ-024 After SAMPLE, if v<15 the block SHALL increment v and return to APPLY; otherwise it SHALL go to NEXT.
REQ-025 NEXT SHALL clear v and advance to the next fault, or go to DONE after fault NUM_FAULTS-1.
REQ-026 Each vector SHALL take SETTLE+1 cycles and each fault SHALL take 16*(SETTLE+1)+1 cycles.
REQ-027 DONE SHALL assert done for one cycle, drop busy and fault_en, and return to IDLE.
REQ-028 busy SHALL be high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-029 total_mism SHALL saturate at 255, and per-fault counts SHALL saturate at 16.
REQ-030 rd_first and rd_cnt SHALL be combinational reads of stored results.
REQ-031 For rd_idx>=NUM_FAULTS, rd_first SHALL return 4'hF and rd_cnt SHALL return 0.
REQ-032 Results SHALL persist in IDLE until the next accepted start.
REQ-033 If start and rst are asserted together, rst SHALL win.

Reset
REQ-034 While rst=1 the block SHALL enter IDLE and drive vec_*=0, fault_en=0, fault_sel=0, busy=0, done=0, detected=0, total_mism=0.
REQ-035 While rst=1 every per-fault count SHALL be 0 and every rd_first SHALL be 4'hF.
REQ-036 rst asserted mid-campaign SHALL abort the campaign in the same cycle, with no done pulse and no partial results retained.

Verification
REQ-037 Correct fault-injecting DUT, SETTLE=1, start pulse -> per-fault rd_cnt = 12,4,12,4,6,10 for faults 0..5; total_mism=48; detected=6'h3F; done exactly 6*33 cycles after busy rises.
REQ-038 Same run as REQ-037 -> rd_first = 4,0,0,1,0,1 for faults 0..5.
REQ-039 DUT ignoring fault_en (always golden) -> detected=0, total_mism=0, all rd_first=4'hF, rd_cnt=0.
REQ-040 SETTLE=3 with DUT output delayed 3 cycles -> same results as REQ-037; 16*4+1 cycles per fault.
REQ-041 rst pulsed during fault 2 -> busy=0, no done pulse, all results at reset values; a new start runs a full campaign to REQ-037 results.
REQ-042 start re-pulsed while busy, and rd_idx=7 -> no restart, run completes normally; rd_first=4'hF, rd_cnt=0.
